// File: rtl/uart_stream_pkg.sv
// Shared types and 16550 register map for the UART Wishbone byte streamer.
// Holds the FSM state encoding and the init constants.
package uart_stream_pkg;

    typedef enum logic [2:0] {
        INIT_LCR_DLAB,
        INIT_DLL,
        INIT_DLM,
        INIT_LCR,
        INIT_FCR,
        IDLE,
        POLL_LSR,
        WRITE_THR
    } state_e;

    localparam logic [2:0] ADR_THR = 3'd0;
    localparam logic [2:0] ADR_DLL = 3'd0;
    localparam logic [2:0] ADR_DLM = 3'd1;
    localparam logic [2:0] ADR_FCR = 3'd2;
    localparam logic [2:0] ADR_LCR = 3'd3;
    localparam logic [2:0] ADR_LSR = 3'd5;

    localparam int         LSR_THRE_BIT = 5;
    localparam logic [7:0] FCR_INIT     = 8'h07;
    localparam logic [7:0] LCR_DLAB     = 8'h80;

    function automatic logic lsr_thre(input logic [7:0] lsr);
        logic [7:0] mask;
        mask = 8'h01 << LSR_THRE_BIT;
        return (lsr & mask) != 8'h00;
    endfunction

endpackage

// File: rtl/uart_wb_streamer_if.sv
// Wishbone classic 8-bit bus bundle between the streamer and a UART.
// master drives the request side, slave returns data and ack.
interface uart_wb_streamer_if;

    logic [2:0] adr;
    logic [7:0] dat_w;
    logic [7:0] dat_r;
    logic       we;
    logic       stb;
    logic       cyc;
    logic       ack;

    modport master (
        output adr, dat_w, we, stb, cyc,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, we, stb, cyc,
        output dat_r, ack
    );

endinterface

// File: rtl/uart_stream_fifo.sv
// Synchronous byte FIFO with occupancy level; power-of-two depth so
// the pointers wrap for free.
module uart_stream_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    data_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign data_o  = mem[rd_q];

    // A pop frees the head slot, so a concurrent push may land when full.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_q] <= data_i;
    end

endmodule

// File: rtl/uart_wb_streamer.sv
// Wishbone master that programs a 16550 UART and then streams
// buffered bytes into THR, polling LSR.THRE before each burst.
module uart_wb_streamer
    import uart_stream_pkg::*;
#(
    parameter  logic [15:0] DIVISOR    = 16'd27,
    parameter  logic [7:0]  LCR_VAL    = 8'h03,
    parameter  int          FIFO_DEPTH = 16,
    parameter  int          TX_BURST   = 16,
    localparam int          LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [7:0]    s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [2:0]    wb_adr_o,
    output logic [7:0]    wb_dat_o,
    input  logic [7:0]    wb_dat_i,
    output logic          wb_we_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic          wb_ack_i,
    output logic          init_done_o,
    output logic [LW-1:0] fifo_level_o
);

    localparam int BW = $clog2(TX_BURST + 1);

    state_e        state_q, state_d, nxt;
    logic          cyc_q, cyc_d;
    logic [2:0]    adr_q, adr_d, tgt_adr;
    logic [7:0]    dat_q, dat_d, tgt_dat;
    logic          we_q, we_d, tgt_we;
    logic [BW-1:0] burst_q, burst_d;
    logic          done_q, done_d;
    logic          rdy_q;

    logic          push, pop, full, empty, last;
    logic [7:0]    head;
    logic [LW-1:0] level;

    uart_stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push),
        .data_i  (s_data_i),
        .pop_i   (pop),
        .data_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign s_ready_o    = rdy_q & ~full;
    assign push         = s_valid_i & s_ready_o;
    assign fifo_level_o = level;
    assign init_done_o  = done_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_we_o      = we_q;

    // Burst ends on count, or when this pop drains the buffer.
    assign last = (burst_q == BW'(TX_BURST - 1)) ||
                  (level == LW'(1) && !push);

    always_comb begin
        tgt_adr = ADR_THR;
        tgt_dat = 8'h00;
        tgt_we  = 1'b1;
        nxt     = state_q;
        unique case (state_q)
            INIT_LCR_DLAB: begin
                tgt_adr = ADR_LCR;
                tgt_dat = LCR_VAL | LCR_DLAB;
                nxt     = INIT_DLL;
            end
            INIT_DLL: begin
                tgt_adr = ADR_DLL;
                tgt_dat = DIVISOR[7:0];
                nxt     = INIT_DLM;
            end
            INIT_DLM: begin
                tgt_adr = ADR_DLM;
                tgt_dat = DIVISOR[15:8];
                nxt     = INIT_LCR;
            end
            INIT_LCR: begin
                tgt_adr = ADR_LCR;
                tgt_dat = LCR_VAL;
                nxt     = INIT_FCR;
            end
            INIT_FCR: begin
                tgt_adr = ADR_FCR;
                tgt_dat = FCR_INIT;
                nxt     = IDLE;
            end
            POLL_LSR: begin
                tgt_adr = ADR_LSR;
                tgt_we  = 1'b0;
                nxt     = lsr_thre(wb_dat_i) ? WRITE_THR : IDLE;
            end
            WRITE_THR: begin
                tgt_adr = ADR_THR;
                tgt_dat = head;
                nxt     = last ? IDLE : WRITE_THR;
            end
            default: begin
                tgt_we = 1'b0;
                nxt    = IDLE;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        burst_d = burst_q;
        done_d  = done_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            if (!empty) state_d = POLL_LSR;
        end else if (!cyc_q) begin
            cyc_d = 1'b1;
            adr_d = tgt_adr;
            dat_d = tgt_dat;
            we_d  = tgt_we;
        end else if (wb_ack_i) begin
            // Idle the bus for a cycle between transfers.
            cyc_d   = 1'b0;
            adr_d   = '0;
            dat_d   = '0;
            we_d    = 1'b0;
            state_d = nxt;
            if (state_q == INIT_FCR) done_d = 1'b1;
            if (state_q == POLL_LSR) burst_d = '0;
            if (state_q == WRITE_THR) begin
                pop     = 1'b1;
                burst_d = burst_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= INIT_LCR_DLAB;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            burst_q <= '0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            done_q  <= done_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_wb_streamer.sv
// Directed bench for uart_wb_streamer: UART slave model with a
// transaction scoreboard, plus a direct check of the byte FIFO.
module tb_uart_wb_streamer;
    import uart_stream_pkg::*;

    typedef struct {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       init_done;
    logic [4:0] level;

    logic       f_push, f_pop, f_full, f_empty;
    logic [7:0] f_din, f_dout;
    logic [4:0] f_level;

    txn_t       exp_q[$];
    logic [7:0] lsr_q[$];
    logic [7:0] fq[$];
    logic [7:0] lsr_def;
    int         lat;
    int         wcnt;
    logic [2:0] s_adr;
    logic [7:0] s_dat;
    logic       fcr_acked;
    logic       saw_full;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    uart_wb_streamer_if bus ();

    uart_wb_streamer dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .wb_adr_o     (bus.adr),
        .wb_dat_o     (bus.dat_w),
        .wb_dat_i     (bus.dat_r),
        .wb_we_o      (bus.we),
        .wb_stb_o     (bus.stb),
        .wb_cyc_o     (bus.cyc),
        .wb_ack_i     (bus.ack),
        .init_done_o  (init_done),
        .fifo_level_o (level)
    );

    uart_stream_fifo #(.DEPTH(16)) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (f_push),
        .data_i  (f_din),
        .pop_i   (f_pop),
        .data_o  (f_dout),
        .level_o (f_level),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_w(input logic [2:0] a, input logic [7:0] d);
        txn_t t;
        t.we = 1'b1; t.adr = a; t.dat = d;
        exp_q.push_back(t);
    endtask

    task automatic exp_r();
        txn_t t;
        t.we = 1'b0; t.adr = ADR_LSR; t.dat = 8'h00;
        exp_q.push_back(t);
    endtask

    task automatic exp_init();
        exp_w(3'd3, 8'h83);
        exp_w(3'd0, 8'h1B);
        exp_w(3'd1, 8'h00);
        exp_w(3'd3, 8'h03);
        exp_w(3'd2, 8'h07);
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_cyc"}, bus.cyc, 0);
        chk({tag, "_stb"}, bus.stb, 0);
        chk({tag, "_we"}, bus.we, 0);
        chk({tag, "_adr"}, bus.adr, 0);
        chk({tag, "_dat"}, bus.dat_w, 0);
        chk({tag, "_done"}, init_done, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_ready"}, s_ready, 0);
    endtask

    task automatic push_byte(input logic [7:0] d);
        int t;
        t = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", s_ready, 1);
        @(negedge clk);
    endtask

    task automatic wait_init(input string tag);
        int t;
        t = 0;
        while (!init_done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_init_done"}, init_done, 1);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || level != 0 || bus.cyc) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_level"}, level, 0);
    endtask

    // UART slave: acks after lat extra cycles, scores every transfer.
    always @(negedge clk) begin
        txn_t e;
        if (rst) begin
            bus.ack = 1'b0;
            wcnt    = 0;
            fcr_acked = 1'b0;
        end else if (bus.ack) begin
            chk("cyc_gap", bus.cyc, 0);
            if (fcr_acked) chk("done_after_fcr", init_done, 1);
            fcr_acked = 1'b0;
            bus.ack = 1'b0;
            wcnt    = 0;
        end else if (bus.cyc && bus.stb) begin
            if (wcnt == 0) begin
                s_adr = bus.adr;
                s_dat = bus.dat_w;
            end else begin
                chk("stable_adr", bus.adr, s_adr);
                chk("stable_dat", bus.dat_w, s_dat);
            end
            if (wcnt >= lat) begin
                chk("txn_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("txn_we", bus.we, e.we);
                    chk("txn_adr", bus.adr, e.adr);
                    if (e.we) chk("txn_dat", bus.dat_w, e.dat);
                end
                if (bus.we && bus.adr == ADR_FCR) begin
                    chk("done_before_fcr", init_done, 0);
                    fcr_acked = 1'b1;
                end
                if (!bus.we)
                    bus.dat_r = (lsr_q.size() != 0) ? lsr_q.pop_front() : lsr_def;
                bus.ack = 1'b1;
            end else begin
                wcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && level == 5'd16) begin
            chk("ready_at_full", s_ready, 0);
            saw_full = 1'b1;
        end
    end

    initial begin
        bus.ack = 1'b0; bus.dat_r = 8'h00;
        s_valid = 1'b0; s_data = 8'h00;
        f_push = 1'b0; f_pop = 1'b0; f_din = 8'h00;
        lat = 0; lsr_def = 8'h60; saw_full = 1'b0;

        // Power-on reset and init sequence.
        exp_init();
        repeat (3) @(negedge clk);
        rst_checks("por");
        rst = 1'b0;
        #1 chk("ready_in_release", s_ready, 0);
        @(negedge clk);
        chk("ready_after_release", s_ready, 1);
        wait_init("boot");
        chk("boot_left", exp_q.size(), 0);

        // Stray ack with no cycle open must do nothing.
        @(negedge clk);
        #1 bus.ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_ack_cyc", bus.cyc, 0);

        // Three bytes, THRE set.
        exp_r();
        exp_w(ADR_THR, 8'hA1);
        exp_w(ADR_THR, 8'hB2);
        exp_w(ADR_THR, 8'hC3);
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        s_valid = 1'b0;
        wait_drain("three");

        // THRE clear for five polls, slow acks.
        lat = 3;
        for (int i = 0; i < 5; i++) begin
            lsr_q.push_back(8'h00);
            exp_r();
        end
        lsr_q.push_back(8'h20);
        exp_r();
        exp_w(ADR_THR, 8'hD4);
        push_byte(8'hD4);
        s_valid = 1'b0;
        wait_drain("thre_wait");

        // Twenty bytes buffered during a slow init: burst limit.
        lat = 6;
        @(negedge clk);
        rst = 1'b1;
        #1 rst_checks("rst2");
        exp_q.delete();
        lsr_q.delete();
        saw_full = 1'b0;
        exp_init();
        exp_r();
        for (int i = 0; i < 16; i++) exp_w(ADR_THR, 8'(i));
        exp_r();
        for (int i = 16; i < 20; i++) exp_w(ADR_THR, 8'(i));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) push_byte(8'(i));
        s_valid = 1'b0;
        wait_drain("burst");
        chk("burst_saw_full", saw_full, 1);
        chk("burst_done", init_done, 1);

        // Reset in the middle of a THR write.
        lat = 2;
        exp_r();
        push_byte(8'hE0);
        push_byte(8'hE1);
        s_valid = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #1;
            if (bus.cyc && bus.we && bus.adr == ADR_THR) break;
        end
        chk("mid_thr_seen", bus.cyc && bus.we, 1);
        rst = 1'b1;
        #1 rst_checks("mid");
        chk("mid_left", exp_q.size(), 0);
        exp_q.delete();
        exp_init();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_init("reinit");
        repeat (20) @(negedge clk);
        chk("reinit_left", exp_q.size(), 0);
        chk("reinit_level", level, 0);
        chk("reinit_cyc", bus.cyc, 0);

        // FIFO push+pop at level 16 and level 1 across wrap.
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            f_din = 8'(8'h40 + i);
            f_push = 1'b1;
            fq.push_back(f_din);
            @(negedge clk);
        end
        f_push = 1'b0;
        chk("fifo_level16", f_level, 16);
        chk("fifo_full", f_full, 1);
        f_din = 8'h5A; f_push = 1'b1; f_pop = 1'b1;
        chk("fifo_head16", f_dout, fq.pop_front());
        fq.push_back(8'h5A);
        @(negedge clk);
        f_push = 1'b0; f_pop = 1'b0;
        chk("fifo_pp16_level", f_level, 16);
        for (int i = 0; i < 15; i++) begin
            f_pop = 1'b1;
            chk("fifo_order", f_dout, fq.pop_front());
            @(negedge clk);
        end
        f_pop = 1'b0;
        chk("fifo_level1", f_level, 1);
        f_din = 8'h6B; f_push = 1'b1; f_pop = 1'b1;
        chk("fifo_head1", f_dout, fq.pop_front());
        fq.push_back(8'h6B);
        @(negedge clk);
        f_push = 1'b0; f_pop = 1'b0;
        chk("fifo_pp1_level", f_level, 1);
        f_pop = 1'b1;
        chk("fifo_last", f_dout, fq.pop_front());
        @(negedge clk);
        f_pop = 1'b0;
        chk("fifo_level0", f_level, 0);
        chk("fifo_empty", f_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
